// File: rtl/removal_sweep_ctrl.sv
// removal_sweep_ctrl: loads a WIDTH x DEPTH occupancy grid as a row stream, then
// runs repeated Jacobi removal passes, one row per cycle, until a pass removes
// nothing or the pass limit 2**PASS_W-1 is reached.
module removal_sweep_ctrl #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 10,
    parameter int CNT_W  = $clog2(WIDTH*DEPTH+1),
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [WIDTH-1:0]  row_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  pass_removed,
    output logic [CNT_W-1:0]  total_removed,
    output logic [PASS_W-1:0] pass_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST     = IDX_W'(DEPTH-1);
    localparam logic [PASS_W-1:0] PASS_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SWEEP, S_CHECK, S_DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   grid [DEPTH];
    logic [WIDTH-1:0]   prev_row;      // pre-update copy of row r-1
    logic [IDX_W-1:0]   idx;           // load row index, then sweep row r
    logic [CNT_W-1:0]   acc;
    logic [WIDTH-1:0]   above, cur, below, clear;
    logic [WIDTH+1:0]   above_p, cur_p, below_p;
    logic [3:0]         nbr;
    logic [CNT_W-1:0]   clear_cnt;
    logic [PASS_W-1:0]  pass_inc;
    logic               accept;

    assign accept   = row_valid && row_ready;
    assign pass_inc = pass_count + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_LOAD;
            S_LOAD:         if (accept && idx == LAST) state_next = S_SWEEP;
            S_SWEEP:        if (idx == LAST) state_next = S_CHECK;
            S_CHECK: begin
                if (acc == '0 || pass_inc == PASS_MAX) state_next = S_DONE;
                else                                   state_next = S_SWEEP;
            end
            default:        state_next = S_IDLE;
        endcase
    end

    // Neighbour count and removal mask for the row being swept; the rows
    // outside the grid and the columns outside the row are zero-padded.
    always_comb begin
        above     = (idx == '0)  ? '0 : prev_row;
        cur       = grid[idx];
        below     = (idx == LAST) ? '0 : grid[idx + 1'b1];
        above_p   = {1'b0, above, 1'b0};
        cur_p     = {1'b0, cur,   1'b0};
        below_p   = {1'b0, below, 1'b0};
        clear     = '0;
        clear_cnt = '0;
        nbr       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nbr = 4'(above_p[i]) + 4'(above_p[i+1]) + 4'(above_p[i+2])
                + 4'(below_p[i]) + 4'(below_p[i+1]) + 4'(below_p[i+2])
                + 4'(cur_p[i])   + 4'(cur_p[i+2]);
            clear[i]  = cur[i] && (nbr < 4'd4);
            clear_cnt = clear_cnt + CNT_W'(clear[i]);
        end
    end

    // Grid storage, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) grid[r] <= '0;
            prev_row      <= '0;
            idx           <= '0;
            acc           <= '0;
            row_ready     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            pass_removed  <= '0;
            total_removed <= '0;
            pass_count    <= '0;
        end else begin
            row_ready <= (state_next == S_LOAD);
            busy      <= (state_next == S_LOAD) || (state_next == S_SWEEP) ||
                         (state_next == S_CHECK);
            done      <= (state_next == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx           <= '0;
                        acc           <= '0;
                        prev_row      <= '0;
                        overflow      <= 1'b0;
                        pass_removed  <= '0;
                        total_removed <= '0;
                        pass_count    <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        grid[idx] <= row_data;
                        idx       <= (idx == LAST) ? '0 : idx + 1'b1;
                    end
                end
                S_SWEEP: begin
                    // Row r+1 is still unmodified; row r's original goes to prev_row.
                    grid[idx] <= cur & ~clear;
                    prev_row  <= cur;
                    acc       <= acc + clear_cnt;
                    idx       <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                S_CHECK: begin
                    pass_removed  <= acc;
                    total_removed <= total_removed + acc;
                    pass_count    <= pass_inc;
                    if (acc != '0 && pass_inc == PASS_MAX) overflow <= 1'b1;
                    acc      <= '0;
                    idx      <= '0;
                    prev_row <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
